// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI word receiver: FSM state encoding,
// per-mode CPOL/CPHA decode, and the default word width and DAC reset code.
package dac_spi_pkg;

    localparam int          DEF_WORD_BITS  = 16;
    localparam logic [15:0] DAC_RESET_CODE = 16'h9E23;

    // Bit n holds the CPOL / CPHA value of SPI mode n.
    localparam logic [3:0] MODE_CPOL = 4'b1100;
    localparam logic [3:0] MODE_CPHA = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_OVER,
        ST_ABORT
    } rx_state_t;

    function automatic logic mode_cpol(input int mode);
        logic [1:0] m;
        m = mode[1:0];
        return MODE_CPOL[m];
    endfunction

    function automatic logic mode_cpha(input int mode);
        logic [1:0] m;
        m = mode[1:0];
        return MODE_CPHA[m];
    endfunction

    function automatic logic mode_samples_on_rise(input int mode);
        return mode_cpol(mode) == mode_cpha(mode);
    endfunction

endpackage

// File: rtl/dac_spi_word_receiver_if.sv
// Pin-side and result-side signals of the DAC SPI word receiver.
// Carries the delta output only when DAC_RX_DELTA_EN is defined.
interface dac_spi_word_receiver_if
    import dac_spi_pkg::*;
#(
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int CNT_W     = 16
);
    logic                   spi_clk;
    logic                   spi_mosi;
    logic                   spi_cs_n;
    logic [WORD_BITS-1:0]   word;
    logic                   word_valid;
    logic                   frame_err;
    logic                   busy;
    logic [CNT_W-1:0]       frame_count;
    logic [CNT_W-1:0]       err_count;
`ifdef DAC_RX_DELTA_EN
    logic signed [WORD_BITS:0] delta;
`endif

    modport slave (
        input  spi_clk, spi_mosi, spi_cs_n,
        output word, word_valid, frame_err, busy, frame_count, err_count
`ifdef DAC_RX_DELTA_EN
        , output delta
`endif
    );

    modport master (
        output spi_clk, spi_mosi, spi_cs_n,
        input  word, word_valid, frame_err, busy, frame_count, err_count
`ifdef DAC_RX_DELTA_EN
        , input delta
`endif
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin plus a history flop
// that yields single-cycle rise/fall strobes.
module spi_pin_sync #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_hist <= RST_VAL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;
endmodule

// File: rtl/dac_spi_word_receiver.sv
// Oversampling SPI responder: rebuilds each CS_n frame into a DAC word, flags
// short/long/stalled frames. Optional delta output under DAC_RX_DELTA_EN.
//
// state    | meaning
// ST_IDLE  | waiting for CS_n fall
// ST_SHIFT | collecting bits, stall timer running
// ST_OVER  | more than WORD_BITS edges seen, waiting for CS_n rise
// ST_ABORT | stall timeout reported, waiting for CS_n rise
module dac_spi_word_receiver
    import dac_spi_pkg::*;
#(
    parameter int WORD_BITS      = DEF_WORD_BITS,
    parameter int SPI_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                    clk50,
    input  logic                    reset,
    dac_spi_word_receiver_if.slave  bus
);
    localparam bit              SCK_IDLE    = mode_cpol(SPI_MODE);
    localparam bit              SAMPLE_RISE = mode_samples_on_rise(SPI_MODE);
    localparam int              BC_W        = $clog2(WORD_BITS + 2);
    localparam int              TM_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TM_W-1:0] TM_LOAD     = TM_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BC_W-1:0] BC_FULL     = BC_W'(WORD_BITS);

    logic w_sck_rise, w_sck_fall, w_sck_level;
    logic w_cs_rise, w_cs_fall, w_cs_level;
    logic w_mosi_level, w_mosi_rise, w_mosi_fall;
    logic w_unused_pins;
    logic w_sample;

    spi_pin_sync #(.RST_VAL(SCK_IDLE)) u_sync_sck (
        .i_clk(clk50), .i_reset(reset), .i_pin(bus.spi_clk),
        .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk(clk50), .i_reset(reset), .i_pin(bus.spi_cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(clk50), .i_reset(reset), .i_pin(bus.spi_mosi),
        .o_level(w_mosi_level), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_pins = w_sck_level ^ w_mosi_rise ^ w_mosi_fall;
    assign w_sample      = SAMPLE_RISE ? w_sck_rise : w_sck_fall;

    rx_state_t              r_state, w_state_nxt;
    logic [BC_W-1:0]        r_bit_cnt;
    logic [TM_W-1:0]        r_timer;
    logic [WORD_BITS-1:0]   r_shift;
    logic                   r_good_q, r_bad_q;
    logic [1:0]             r_arm_cnt;
    logic                   r_armed;
    logic [WORD_BITS-1:0]   r_word;
    logic                   r_word_valid, r_frame_err;
    logic [CNT_W-1:0]       r_frame_count, r_err_count;
    logic                   w_start, w_shift_en, w_good, w_bad;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_state_nxt = ST_SHIFT;
                    w_start     = 1'b1;
                end
            end
            ST_SHIFT: begin
                // A sample edge coinciding with CS_n rise is dropped.
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_good      = (r_bit_cnt == BC_FULL);
                    w_bad       = (r_bit_cnt != BC_FULL);
                end else if (w_sample) begin
                    if (r_bit_cnt == BC_FULL) w_state_nxt = ST_OVER;
                    else                      w_shift_en  = 1'b1;
                end else if (r_timer == '0) begin
                    w_state_nxt = ST_ABORT;
                    w_bad       = 1'b1;
                end
            end
            ST_OVER: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_bad       = 1'b1;
                end
            end
            ST_ABORT: begin
                if (w_cs_rise) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // After reset, only a CS_n fall preceded by a settled high level starts a frame.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            if (r_arm_cnt != 2'd3) r_arm_cnt <= r_arm_cnt + 2'd1;
            if (r_arm_cnt == 2'd3 && w_cs_level) r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_shift   <= '0;
            r_good_q  <= 1'b0;
            r_bad_q   <= 1'b0;
        end else begin
            r_good_q <= w_good;
            r_bad_q  <= w_bad;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_timer   <= TM_LOAD;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[WORD_BITS-2:0], w_mosi_level};
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
                r_timer   <= TM_LOAD;
            end else if (r_state == ST_SHIFT && r_timer != '0) begin
                r_timer <= r_timer - TM_W'(1);
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_word        <= '0;
            r_word_valid  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            r_word_valid <= r_good_q;
            r_frame_err  <= r_bad_q;
            if (r_good_q) begin
                r_word        <= r_shift;
                r_frame_count <= r_frame_count + CNT_W'(1);
            end
            if (r_bad_q && r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
        end
    end

`ifdef DAC_RX_DELTA_EN
    logic                       r_have_word;
    logic signed [WORD_BITS:0]  r_delta;

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_have_word <= 1'b0;
            r_delta     <= '0;
        end else if (r_good_q) begin
            r_have_word <= 1'b1;
            r_delta     <= r_have_word ? ($signed({1'b0, r_shift}) - $signed({1'b0, r_word}))
                                       : '0;
        end
    end

    assign bus.delta = r_delta;
`endif

    assign bus.word        = r_word;
    assign bus.word_valid  = r_word_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.frame_count = r_frame_count;
    assign bus.err_count   = r_err_count;
endmodule

// File: doc/dac_spi_word_receiver.md
Name: dac_spi_word_receiver

Overview:
- SPI responder (slave-side deserializer) for the DAC SPI link driven by the SPI master in the DPLL top level.
- Oversamples SCK/MOSI/CS_n on clk50, reassembles each CS frame into a 16-bit DAC code, and flags malformed frames.
- Used as an on-board loopback monitor so the UART register monitor can read back the code actually shifted to the DAC.
- Also serves as a DAC behavioural responder in benches.

Parameters:
- WORD_BITS, 16, data bits per CS-low frame (MSB first).
- SPI_MODE, 0, SPI mode 0..3; sample on the leading edge when CPHA=0, on the trailing edge when CPHA=1.
- TIMEOUT_CYCLES, 4096, clk50 cycles with CS low and no sample edge before the frame is aborted.
- CNT_W, 16, width of the frame counter.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- spi_clk  in  1  DAC_clk pin, asynchronous to clk50.
- spi_mosi  in  1  DAC_data pin, asynchronous.
- spi_cs_n  in  1  DAC_CS_n pin, asynchronous, active low.
- word  out  WORD_BITS  last good word; holds until the next good frame.
- word_valid  out  1  one-cycle pulse when word updates.
- frame_err  out  1  one-cycle pulse on a bad or aborted frame.
- busy  out  1  high while a frame is in progress.
- frame_count  out  CNT_W  good frames received; wraps at 2^CNT_W.
- err_count  out  CNT_W  bad frames received; saturates at all-ones.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register 0; sync flops cleared to the idle bus level (SCK=CPOL, CS_n=1, MOSI=0).
- Synchronization:
  - 2-flop synchronizer on each input, then one history flop for edge detection.
  - An edge is visible 3 clk50 cycles after the pin edge.
  - SCK high and low times must each be at least 3 clk50 periods; faster SCK is unsupported and not detected.
- Sample edge:
  - Mode 0: SCK rise.
  - Mode 1: SCK fall.
  - Mode 2: SCK fall.
  - Mode 3: SCK rise.
- FSM states: IDLE, SHIFT, OVER, ABORT.
- IDLE:
  - busy=0.
  - CS_n falling -> SHIFT; bit_cnt=0, timer=0.
- SHIFT:
  - busy=1.
  - On a sample edge: shift in MOSI (MSB first), bit_cnt+1, timer=0. Otherwise timer+1.
  - Sample edge with bit_cnt==WORD_BITS -> OVER (17th bit).
  - Timer reaches TIMEOUT_CYCLES-1 -> ABORT.
  - CS_n rising -> IDLE.
    - bit_cnt==WORD_BITS: the next cycle drives word=shift reg, word_valid=1, frame_count+1.
    - Otherwise (short frame, including 0 bits): frame_err=1, err_count+1.
- OVER: ignore SCK; CS_n rising -> IDLE with frame_err pulse; word unchanged.
- ABORT: frame_err pulse on entry (once); wait for CS_n high -> IDLE.
- Latency: word_valid is 1 cycle after the synchronized CS_n rise, i.e. 4 clk50 cycles after the pin edge.
- Simultaneous events:
  - A sample edge and a CS_n rise in the same cycle: the edge is discarded and the frame is judged on the prior bit_cnt.
  - A CS_n fall in the same cycle as word_valid: the new frame starts normally.
- word_valid and frame_err are never high together.
- Reset mid-frame: the frame is dropped with no pulse. If CS is still low when reset releases, the FSM stays in IDLE until the next CS_n fall; the partial frame is ignored.

Optional Feature:
- Macro: DAC_RX_DELTA_EN.
- Defined: adds output delta (signed, WORD_BITS+1 bits) = word_new - word_prev.
  - Updated together with word_valid.
  - The first good frame after reset gives delta=0.
  - Mirrors the DPLL pid_out step for monitoring.
- Undefined: no delta port, and no previous-word register.

Decomposition:
- Shared package dac_spi_pkg holds:
  - fsm state enum (IDLE/SHIFT/OVER/ABORT);
  - SPI mode decode constants (CPOL/CPHA per mode);
  - default WORD_BITS=16;
  - DAC reset code 16'h9E23.
- One natural sub-module: spi_pin_sync (per-pin 2-flop sync plus rise/fall detect), instantiated three times.

Test Plan:
- Mode 0, SCK half period 10 cycles, send 16'h9E23 in one CS frame -> word=16'h9E23, single word_valid pulse 4 cycles after CS_n rise, frame_count=1.
- Send 15 bits of 16'hFFFF then raise CS_n -> frame_err pulse, err_count=1, word unchanged (16'h9E23).
- Send 17 bits -> OVER, frame_err on CS_n rise, word unchanged.
- CS_n low, 8 bits, then SCK stops for 5000 cycles -> frame_err at TIMEOUT_CYCLES, busy=1 until CS_n rises.
- Assert reset after 9 bits, release with CS still low, finish the frame, then send 16'h1234 -> no pulse for the broken frame; word=16'h1234, frame_count=1.
- With DAC_RX_DELTA_EN: send 16'h9E23 then 16'h9E00 -> delta=0 then delta=-35.
